pipelined_sram: RTL

//   Parametrised single-clock SRAM bank: one write port, one read port.

---
 rtl/pipelined_sram.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipelined_sram.sv
// Single-clock SRAM bank with per-lane write masks, configurable read latency,
// write-first same-cycle forwarding and a post-reset clear engine.
module pipelined_sram #(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 32,
    parameter int LANE_WIDTH     = 8,
    parameter int RD_LATENCY     = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 ren,
    input  logic [ADDR_WIDTH-1:0]                raddr,
    input  logic                                 write,
    input  logic [ADDR_WIDTH-1:0]                waddr,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]     wmask,
    input  logic signed [DATA_WIDTH-1:0]         din,
    output logic signed [DATA_WIDTH-1:0]         dout,
    output logic                                 dout_valid,
    output logic                                 ready
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    generate
        if (DATA_WIDTH % LANE_WIDTH != 0) begin : gen_bad_lane_width
            $error("pipelined_sram: DATA_WIDTH must be a multiple of LANE_WIDTH");
        end
        if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : gen_bad_rd_latency
            $error("pipelined_sram: RD_LATENCY must be in 1..4");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clearAddr_q, clearAddr_d;

    logic                    wrEn_q;
    logic [ADDR_WIDTH-1:0]   wrAddr_q;
    logic [NUM_LANES-1:0]    wrMask_q;
    logic [DATA_WIDTH-1:0]   wrData_q;
    logic                    rdEn_q;
    logic [ADDR_WIDTH-1:0]   rdAddr_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rdMerged;

    logic signed [DATA_WIDTH-1:0] pipeData_q [RD_LATENCY];
    logic [RD_LATENCY-1:0]        pipeVld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            clearAddr_q <= '0;
        end else begin
            state_q     <= state_d;
            clearAddr_q <= clearAddr_d;
        end
    end

    // Clear engine walks every address once, then hands over to RUN for good.
    always_comb begin
        state_d     = state_q;
        clearAddr_d = clearAddr_q;
        if (state_q == ST_CLEAR) begin
            clearAddr_d = clearAddr_q + ADDR_WIDTH'(1);
            if (&clearAddr_q) begin
                state_d = ST_RUN;
            end
        end
    end

    assign ready = (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrEn_q   <= 1'b0;
            wrAddr_q <= '0;
            wrMask_q <= '0;
            wrData_q <= '0;
            rdEn_q   <= 1'b0;
            rdAddr_q <= '0;
        end else begin
            wrEn_q   <= write && ready && (|wmask);
            wrAddr_q <= waddr;
            wrMask_q <= wmask;
            wrData_q <= din;
            rdEn_q   <= ren && ready;
            rdAddr_q <= raddr;
        end
    end

    // The array itself is never reset; only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_CLEAR) begin
                mem[clearAddr_q] <= '0;
            end else if (wrEn_q) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (wrMask_q[l]) begin
                        mem[wrAddr_q][l*LANE_WIDTH +: LANE_WIDTH] <= wrData_q[l*LANE_WIDTH +: LANE_WIDTH];
                    end
                end
            end
        end
    end

    // A write sampled on the same edge as the read commits one edge too late, so forward it.
    always_comb begin
        rdMerged = mem[rdAddr_q];
        if (wrEn_q && (wrAddr_q == rdAddr_q)) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wrMask_q[l]) begin
                    rdMerged[l*LANE_WIDTH +: LANE_WIDTH] = wrData_q[l*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipeVld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipeData_q[i] <= '0;
            end
        end else begin
            pipeVld_q[0] <= rdEn_q;
            if (rdEn_q) begin
                pipeData_q[0] <= rdMerged;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipeVld_q[i] <= pipeVld_q[i-1];
                if (pipeVld_q[i-1]) begin
                    pipeData_q[i] <= pipeData_q[i-1];
                end
            end
        end
    end

    assign dout       = pipeData_q[RD_LATENCY-1];
    assign dout_valid = pipeVld_q[RD_LATENCY-1];

endmodule
